// File: rtl/multi_region_dma_guard.sv
// Multi-region DMA/IRQ kill monitor: holds the core in reset after an illegal
// DMA or interrupt interaction with any protected region, with a minimum hold time.
module multi_region_dma_guard #(
   parameter int                    N_REG         = 2,
   parameter logic [16*N_REG-1:0]   REG_BASE      = {16'h6000, 16'hA100},
   parameter logic [16*N_REG-1:0]   REG_LAST      = {16'h6FFE, 16'hBFFE},
   parameter logic [N_REG-1:0]      REG_DMA_CHK   = 2'b10,
   parameter logic [15:0]           RESET_HANDLER = 16'h0000,
   parameter int                    MIN_KILL      = 4,
   parameter int                    CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      pc,
   input  logic [15:0]      dma_addr,
   input  logic             dma_en,
   input  logic             irq,
   input  logic             clr_cnt,
   output logic             reset,
   output logic             viol,
   output logic [1:0]       viol_cause,
   output logic [N_REG-1:0] viol_region,
   output logic [CNT_W-1:0] viol_cnt
);

   localparam int KW = $clog2(MIN_KILL + 1);

   typedef enum logic {
      ST_KILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // FSM state and hold counter travel together so a checker can bind to one signal.
   typedef struct packed {
      state_t        state;
      logic [KW-1:0] kill_cnt;
   } fsm_t;

   fsm_t             fsm_q, fsm_d;
   logic             reset_q, reset_d;
   logic             viol_q, viol_d;
   logic [1:0]       cause_q, cause_d;
   logic [N_REG-1:0] region_q, region_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N_REG-1:0] in_reg;
   logic [N_REG-1:0] dma_hit;
   logic [N_REG-1:0] pc_hit;
   logic             invalid;
   logic [1:0]       cause_c;
   logic             inc;

   always_comb begin
      in_reg  = '0;
      dma_hit = '0;
      for (int i = 0; i < N_REG; i++) begin
         in_reg[i]  = (pc >= REG_BASE[16*i +: 16]) && (pc <= REG_LAST[16*i +: 16]);
         dma_hit[i] = dma_en && REG_DMA_CHK[i] &&
                      (dma_addr >= REG_BASE[16*i +: 16]) && (dma_addr <= REG_LAST[16*i +: 16]);
      end
      pc_hit  = in_reg & {N_REG{dma_en | irq}};
      invalid = (|pc_hit) | (|dma_hit);
      if (|dma_hit)
         cause_c = 2'b11;
      else if ((|in_reg) && dma_en)
         cause_c = 2'b01;
      else
         cause_c = 2'b10;
   end

   // viol is a single-cycle strobe with no back-pressure; every other output is
   // level-valid on every cycle and changes only on a clock edge.
   always_comb begin
      fsm_d    = fsm_q;
      reset_d  = reset_q;
      viol_d   = 1'b0;
      cause_d  = cause_q;
      region_d = region_q;
      inc      = 1'b0;
      case (fsm_q.state)
         ST_RUN: begin
            if (invalid) begin
               fsm_d.state    = ST_KILL;
               fsm_d.kill_cnt = '0;
               reset_d        = 1'b1;
               viol_d         = 1'b1;
               cause_d        = cause_c;
               region_d       = pc_hit | dma_hit;
               inc            = 1'b1;
            end else begin
               reset_d = 1'b0;
            end
         end
         default: begin
            reset_d = 1'b1;
            if (invalid) begin
               fsm_d.kill_cnt = '0;
            end else if (fsm_q.kill_cnt == KW'(MIN_KILL) && pc == RESET_HANDLER) begin
               fsm_d.state = ST_RUN;
               reset_d     = 1'b0;
            end else if (fsm_q.kill_cnt != KW'(MIN_KILL)) begin
               fsm_d.kill_cnt = fsm_q.kill_cnt + KW'(1);
            end
         end
      endcase
   end

   // A clear coinciding with a new violation still records that violation.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt)
         cnt_d = inc ? CNT_W'(1) : '0;
      else if (inc && !(&cnt_q))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q.state    <= ST_KILL;
         fsm_q.kill_cnt <= '0;
         reset_q        <= 1'b1;
         viol_q         <= 1'b0;
         cause_q        <= 2'b00;
         region_q       <= '0;
         cnt_q          <= '0;
      end else begin
         fsm_q    <= fsm_d;
         reset_q  <= reset_d;
         viol_q   <= viol_d;
         cause_q  <= cause_d;
         region_q <= region_d;
         cnt_q    <= cnt_d;
      end
   end

   assign reset       = reset_q;
   assign viol        = viol_q;
   assign viol_cause  = cause_q;
   assign viol_region = region_q;
   assign viol_cnt    = cnt_q;

endmodule

// File: tb/tb_multi_region_dma_guard.sv
// Directed bench for multi_region_dma_guard: a driver pushes hand-computed
// expected outputs into a queue, a negedge monitor pops and compares them.
module tb_multi_region_dma_guard;

   localparam int W = 14;

   logic        clk;
   logic        rst_n;
   logic [15:0] pc;
   logic [15:0] dma_addr;
   logic        dma_en;
   logic        irq;
   logic        clr_cnt;
   logic        reset;
   logic        viol;
   logic [1:0]  viol_cause;
   logic [1:0]  viol_region;
   logic [7:0]  viol_cnt;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks;
   int           errors;

   logic [1:0]   e_cause;
   logic [1:0]   e_region;
   logic [7:0]   e_cnt;

   multi_region_dma_guard dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .dma_addr    (dma_addr),
      .dma_en      (dma_en),
      .irq         (irq),
      .clr_cnt     (clr_cnt),
      .reset       (reset),
      .viol        (viol),
      .viol_cause  (viol_cause),
      .viol_region (viol_region),
      .viol_cnt    (viol_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got reset=%b viol=%b cause=%b region=%b cnt=%0d expected reset=%b viol=%b cause=%b region=%b cnt=%0d",
                  nm, act[13], act[12], act[11:10], act[9:8], act[7:0],
                  exp[13], exp[12], exp[11:10], exp[9:8], exp[7:0]);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         check(name_q.pop_front(), {reset, viol, viol_cause, viol_region, viol_cnt}, exp_q.pop_front());
      end
   end

   // driver tasks
   task automatic cyc(input logic [15:0] p, input logic [15:0] a, input logic en,
                      input logic ir, input logic cl, input logic e_rst, input logic e_v,
                      input string nm);
      pc       = p;
      dma_addr = a;
      dma_en   = en;
      irq      = ir;
      clr_cnt  = cl;
      exp_q.push_back({e_rst, e_v, e_cause, e_region, e_cnt});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic violate(input logic [15:0] p, input logic [15:0] a, input logic en,
                          input logic ir, input logic cl, input logic [1:0] c,
                          input logic [1:0] r, input string nm);
      e_cause  = c;
      e_region = r;
      if (cl)
         e_cnt = 8'd1;
      else if (e_cnt != 8'hFF)
         e_cnt = e_cnt + 8'd1;
      cyc(p, a, en, ir, cl, 1'b1, 1'b1, nm);
   endtask

   task automatic recover(input string nm);
      repeat (4) cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {nm, "_hold"});
      cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_release"});
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
         exp_q.delete();
         name_q.delete();
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      e_cause  = 2'b00;
      e_region = 2'b00;
      e_cnt    = 8'd0;
      rst_n    = 1'b0;
      pc       = 16'h0000;
      dma_addr = 16'h0000;
      dma_en   = 1'b0;
      irq      = 1'b0;
      clr_cnt  = 1'b0;

      repeat (2) cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_values");
      rst_n = 1'b1;
      recover("t1_min_kill");

      violate(16'hA200, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, "t2_pc_dma");
      recover("t2");

      violate(16'h4000, 16'h6010, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, "t3_dma_hit");
      recover("t3");
      cyc(16'h4000, 16'hA200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t3_dma_unchecked");

      cyc(16'hA0FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t4_below_base");
      cyc(16'hBFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t4_above_last");
      violate(16'hA100, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, "t4_at_base");
      recover("t4a");
      violate(16'hBFFE, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, "t4_at_last");

      repeat (3) cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t5_hold");
      cyc(16'hA100, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "t5_kill_restart");
      repeat (4) cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t5_rehold");
      cyc(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t5_pc_not_handler");
      cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_release");

      while (e_cnt != 8'hFF) begin
         violate(16'hA200, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, "t6_fill");
         recover("t6_fill");
      end
      violate(16'h4000, 16'h6010, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, "t6_saturate");
      recover("t6_sat");

      violate(16'hA200, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, "t6_clr_with_viol");
      e_cnt = 8'd0;
      cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t6_clr_in_kill");
      cyc(16'h4000, 16'h6010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t6_reviolation_in_kill");
      recover("t6_clr");

      violate(16'hA200, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, "t6_enter_kill");
      drain();
      rst_n = 1'b0;
      #1;
      e_cause  = 2'b00;
      e_region = 2'b00;
      e_cnt    = 8'd0;
      check("t6_async_rst_kill", {reset, viol, viol_cause, viol_region, viol_cnt}, 14'b10_00_00_00000000);
      cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t6_rst_held");
      rst_n = 1'b1;
      recover("t6_after_rst");

      drain();
      rst_n = 1'b0;
      #1;
      check("t6_async_rst_run", {reset, viol, viol_cause, viol_region, viol_cnt}, 14'b10_00_00_00000000);
      #20;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
